// File: rtl/alu_sumsq_sequencer.sv
// alu_sumsq_sequencer: drives the calculator ALU through clear, a^2, b^2, add
// and returns a^2 + b^2 with the OR of the ALU error codes seen during the job.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          job request handshake, operands req_a/req_b
//   rsp_valid/rsp_ready          result handshake, rsp_result/rsp_error
//   alu_p/alu_q/alu_opcode       registered drive to the ALU
//   alu_result/alu_error         ALU feedback register and error code
//
// Optional feature: SEQ_ERR_ABORT_EN
//   defined   - a nonzero alu_error at the SQA/SQB/ADD capture skips to RESP
//               with rsp_result=0 and the accumulated error code.
//   undefined - the full op chain always runs; errors are only accumulated.

module alu_sumsq_sequencer #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int EXP_POW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [1:0]       rsp_error,
    output logic [WIDTH-1:0] alu_p,
    output logic [WIDTH-1:0] alu_q,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_error
);

    localparam logic [3:0] OP_CLR = 4'b1100;
    localparam logic [3:0] OP_EXP = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] LAT    = 4'(ALU_LAT);
    localparam logic [WIDTH-1:0] POW = WIDTH'(EXP_POW);

    typedef enum logic [2:0] {
        IDLE, CLR, SQA, SQB, ADD, RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d, g_q, g_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
    logic [3:0]       op_q, op_d;
    logic             done;
    logic             abort;

    assign done = (cnt_q == LAT);

`ifdef SEQ_ERR_ABORT_EN
    assign abort = (alu_error != 2'b00);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = 4'(cnt_q + 4'd1);
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        g_d     = g_q;
        res_d   = res_q;
        err_d   = err_q;
        op_d    = OP_CLR;
        p_d     = '0;
        q_d     = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    err_d   = 2'b00;
                    state_d = CLR;
                end
            end
            CLR: begin
                if (done) begin
                    err_d   = err_q | alu_error;
                    state_d = SQA;
                end
            end
            SQA: begin
                if (done) begin
                    g_d     = alu_result;
                    err_d   = err_q | alu_error;
                    state_d = SQB;
                end
            end
            SQB: begin
                if (done) begin
                    f_d     = alu_result;
                    err_d   = err_q | alu_error;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (done) begin
                    res_d   = alu_result;
                    err_d   = err_q | alu_error;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides the normal advance; scratch captures still land.
        if (done && abort &&
            (state_q == SQA || state_q == SQB || state_q == ADD)) begin
            res_d   = '0;
            state_d = RESP;
        end

        if (state_d != state_q || state_q == IDLE || state_q == RESP)
            cnt_d = 4'd0;

        // ALU drive is registered, so it is decoded from the next state.
        unique case (state_d)
            SQA: begin
                op_d = OP_EXP;
                p_d  = a_d;
                q_d  = POW;
            end
            SQB: begin
                op_d = OP_EXP;
                p_d  = b_d;
                q_d  = POW;
            end
            ADD: begin
                op_d = OP_ADD;
                p_d  = f_d;
                q_d  = g_d;
            end
            default: begin
                op_d = OP_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            res_q   <= '0;
            err_q   <= 2'b00;
            op_q    <= OP_CLR;
            p_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            g_q     <= g_d;
            res_q   <= res_d;
            err_q   <= err_d;
            op_q    <= op_d;
            p_q     <= p_d;
            q_q     <= q_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = res_q;
    assign rsp_error  = err_q;
    assign alu_p      = p_q;
    assign alu_q      = q_q;
    assign alu_opcode = op_q;

endmodule

// File: tb/tb_alu_sumsq_sequencer.sv
// tb_alu_sumsq_sequencer: directed bench for alu_sumsq_sequencer with a
// one-cycle registered ALU model that flags wrap on exponent and add.

module tb_alu_sumsq_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_error;
    logic [W-1:0] alu_p;
    logic [W-1:0] alu_q;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_result;
    logic [1:0]   alu_error;

    int n_cmp;
    int n_bad;

    alu_sumsq_sequencer #(
        .WIDTH  (W),
        .ALU_LAT(1),
        .EXP_POW(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_error (rsp_error),
        .alu_p     (alu_p),
        .alu_q     (alu_q),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .alu_error (alu_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: exponent flags 01 on wrap, add flags 10 on carry.
    function automatic logic [33:0] alu_eval(input logic [3:0] op,
                                             input logic [31:0] p,
                                             input logic [31:0] q);
        logic [63:0] acc;
        logic [32:0] sum;
        logic        ovf;
        acc = 64'd1;
        ovf = 1'b0;
        sum = 33'd0;
        if (op == 4'b1111) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(q)) begin
                    acc = acc * {32'd0, p};
                    if (acc[63:32] != 32'd0) ovf = 1'b1;
                    acc = {32'd0, acc[31:0]};
                end
            end
            return {ovf ? 2'b01 : 2'b00, acc[31:0]};
        end else if (op == 4'b0000) begin
            sum = {1'b0, p} + {1'b0, q};
            return {sum[32] ? 2'b10 : 2'b00, sum[31:0]};
        end
        return 34'd0;
    endfunction

    always @(posedge clk) begin
        {alu_error, alu_result} <= alu_eval(alu_opcode, alu_p, alu_q);
    end

    logic [3:0] trace [1:16];

    task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy,
                          output int lat, output logic [W-1:0] res,
                          output logic [1:0] err, output logic saw_add);
        lat     = 0;
        res     = '0;
        err     = 2'b00;
        saw_add = 1'b0;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = rdy;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) req_valid = 1'b0;
            if (n <= 16) trace[n] = alu_opcode;
            if (alu_opcode == 4'b0000) saw_add = 1'b1;
            if (rsp_valid) begin
                lat = n;
                res = rsp_result;
                err = rsp_error;
                break;
            end
        end
        if (rdy) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (alu_opcode !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_op got %b want 1100", alu_opcode);
        end
        n_cmp++;
        if (alu_p !== '0 || alu_q !== '0) begin
            n_bad++;
            $display("FAIL reset_pq got %0d/%0d want 0/0", alu_p, alu_q);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
                     rsp_valid, req_ready);
        end
        n_cmp++;
        if (rsp_result !== '0 || rsp_error !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_rsp got %0d/%b want 0/00",
                     rsp_result, rsp_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int         lat;
        logic [W-1:0] res;
        logic [1:0] err;
        logic       sa;
        logic [3:0] exp_ops [1:8];
        exp_ops = '{4'b1100, 4'b1100, 4'b1111, 4'b1111,
                    4'b1111, 4'b1111, 4'b0000, 4'b0000};
        do_job(13, 14, 1'b1, lat, res, err, sa);
        n_cmp++;
        if (lat !== 9) begin
            n_bad++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        n_cmp++;
        if (res !== 365) begin
            n_bad++;
            $display("FAIL basic_result got %0d want 365", res);
        end
        n_cmp++;
        if (err !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_error got %b want 00", err);
        end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (trace[i] !== exp_ops[i]) begin
                n_bad++;
                $display("FAIL basic_trace[%0d] got %b want %b",
                         i, trace[i], exp_ops[i]);
            end
        end
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle got r=%b v=%b want r=1 v=0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [W-1:0] res;
        logic [1:0] err;
        logic       sa;
        do_job(13, 14, 1'b0, lat, res, err, sa);
        n_cmp++;
        if (lat !== 9 || res !== 365) begin
            n_bad++;
            $display("FAIL bp_first got lat=%0d res=%0d want 9/365", lat, res);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_result !== 365 ||
                req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b res=%0d r=%b want 1/365/0",
                         i, rsp_valid, rsp_result, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1",
                     rsp_valid, req_ready);
        end
        do_job(3, 4, 1'b1, lat, res, err, sa);
        n_cmp++;
        if (res !== 25 || err !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_second got %0d/%b want 25/00", res, err);
        end
    endtask

    task automatic test_busy();
        logic found;
        int   bad_ready;
        found     = 1'b0;
        bad_ready = 0;
        req_a     = 13;
        req_b     = 14;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_b = 1;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            if (req_ready !== 1'b0) bad_ready++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!found || bad_ready != 0) begin
            n_bad++;
            $display("FAIL busy_ready got found=%b bad=%0d want 1/0",
                     found, bad_ready);
        end
        n_cmp++;
        if (rsp_result !== 365) begin
            n_bad++;
            $display("FAIL busy_result got %0d want 365", rsp_result);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_idle got r=%b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_accept got r=%b want 0", req_ready);
        end
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!found || rsp_result !== 170) begin
            n_bad++;
            $display("FAIL busy_second got found=%b res=%0d want 1/170",
                     found, rsp_result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_error();
        int         lat;
        logic [W-1:0] res;
        logic [1:0] err;
        logic       sa;
        do_job(3, 65536, 1'b1, lat, res, err, sa);
        n_cmp++;
        if (lat == 0) begin
            n_bad++;
            $display("FAIL err_timeout got no rsp_valid want rsp_valid");
        end
`ifdef SEQ_ERR_ABORT_EN
        n_cmp++;
        if (res !== 0 || err !== 2'b01) begin
            n_bad++;
            $display("FAIL err_abort got %0d/%b want 0/01", res, err);
        end
        n_cmp++;
        if (sa !== 1'b0) begin
            n_bad++;
            $display("FAIL err_add_seen got %b want 0", sa);
        end
`else
        n_cmp++;
        if (res !== 9 || err !== 2'b01) begin
            n_bad++;
            $display("FAIL err_full got %0d/%b want 9/01", res, err);
        end
        n_cmp++;
        if (sa !== 1'b1) begin
            n_bad++;
            $display("FAIL err_add_seen got %b want 1", sa);
        end
`endif
    endtask

    task automatic test_midreset();
        int         lat;
        logic [W-1:0] res;
        logic [1:0] err;
        logic       sa;
        int         seen;
        req_a     = 13;
        req_b     = 14;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (alu_opcode !== 4'b1111 || alu_p !== 14) begin
            n_bad++;
            $display("FAIL mr_sqb got op=%b p=%0d want 1111/14",
                     alu_opcode, alu_p);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (alu_opcode !== 4'b1100 || alu_p !== '0 || alu_q !== '0 ||
            rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_async got op=%b p=%0d q=%0d v=%b r=%b",
                     alu_opcode, alu_p, alu_q, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mr_no_rsp got %0d cycles valid want 0", seen);
        end
        do_job(5, 12, 1'b1, lat, res, err, sa);
        n_cmp++;
        if (lat !== 9 || res !== 169) begin
            n_bad++;
            $display("FAIL mr_next got lat=%0d res=%0d want 9/169", lat, res);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_busy();
        test_error();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
